// File: rtl/mem_pkg.sv
// Shared widths, types and FSM states for the memory responder.
package mem_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Memory bus between the initiator (master) and the responder (slave).
interface mem_responder_if #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W,
  parameter int unsigned CNT_W  = mem_pkg::CNT_W
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output read, write, addr, data_in,
    input  data_out, rd_valid, busy, err, rd_count, wr_count
  );

  modport slave (
    input  read, write, addr, data_in,
    output data_out, rd_valid, busy, err, rd_count, wr_count
  );

endinterface

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one registered read port.
module mem_array #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage write; contents are cleared by the responder's sweep, not by reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory bus responder: post-reset clear sweep, registered reads, error pulse, saturating counters.
module mem_responder #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W,
  parameter int unsigned CNT_W  = mem_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  import mem_pkg::*;

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_e        r_state;
  mem_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;

  logic              w_req_unknown;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_re;
  logic              w_err;
  logic              w_rd_inc;
  logic              w_wr_inc;
  logic [DATA_W-1:0] w_rdata;

  logic              r_busy;
  logic              r_rd_valid;
  logic              r_err;
  logic [CNT_W-1:0]  r_rd_count;
  logic [CNT_W-1:0]  r_wr_count;

  // Undriven or unknown request lines count as a protocol violation.
  always_comb begin
    w_req_unknown = $isunknown({bus.read, bus.write});
  end

  // State and sweep-address register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Next state, write-port mux (sweep vs bus) and request decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_we           = 1'b0;
    w_waddr        = bus.addr;
    w_wdata        = bus.data_in;
    w_re           = 1'b0;
    w_err          = 1'b0;
    w_rd_inc       = 1'b0;
    w_wr_inc       = 1'b0;
    case (r_state)
      CLEAR: begin
        w_we           = ~rst;
        w_waddr        = r_clr_addr;
        w_wdata        = '0;
        w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        w_err          = w_req_unknown | bus.read | bus.write;
        if (r_clr_addr == LAST_ADDR) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        if (w_req_unknown || (bus.read && bus.write)) begin
          w_err = 1'b1;
        end else if (bus.read) begin
          w_re     = ~rst;
          w_rd_inc = 1'b1;
        end else if (bus.write) begin
          w_we     = ~rst;
          w_wr_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Registered status outputs and saturating access counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_busy     <= (w_state_nxt == CLEAR);
      r_rd_valid <= w_re;
      r_err      <= w_err;
      if (w_rd_inc && (r_rd_count != {CNT_W{1'b1}})) begin
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
      if (w_wr_inc && (r_wr_count != {CNT_W{1'b1}})) begin
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (bus.addr),
    .o_rdata (w_rdata)
  );

  assign bus.data_out = w_rdata;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.rd_count = r_rd_count;
  assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a 16-bit-counter and a 4-bit-counter instance driven in lockstep.
module tb_mem_responder;

  localparam int unsigned DEPTH = 32;

  logic clk;
  logic rst;

  mem_responder_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) bus16 ();
  mem_responder_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(4))  bus4  ();

  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .CNT_W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, remaining sweep edges, expected outputs, raw access totals.
  logic [7:0] m [DEPTH];
  int         sweep_left = 0;
  logic [7:0] e_data = 8'h00;
  logic       e_rv = 1'b0;
  logic       e_err = 1'b0;
  int         rc = 0;
  int         wc = 0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive on negedge, advance model at posedge, compare just after.
  task automatic step(input logic rs, input logic r, input logic w,
                      input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = rs;
    bus16.read = r;  bus16.write = w;  bus16.addr = a;  bus16.data_in = d;
    bus4.read  = r;  bus4.write  = w;  bus4.addr  = a;  bus4.data_in  = d;
    @(posedge clk);
    if (rs) begin
      sweep_left = DEPTH;
      foreach (m[i]) m[i] = 8'h00;
      e_data = 8'h00; e_rv = 1'b0; e_err = 1'b0; rc = 0; wc = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      e_rv  = 1'b0;
      e_err = r | w;
    end else begin
      e_rv  = 1'b0;
      e_err = 1'b0;
      if (r && w) begin
        e_err = 1'b1;
      end else if (r) begin
        e_data = m[a]; e_rv = 1'b1; rc++;
      end else if (w) begin
        m[a] = d; wc++;
      end
    end
    #1;
    check("busy",      32'(bus16.busy),     32'(sweep_left > 0));
    check("busy_sat",  32'(bus4.busy),      32'(sweep_left > 0));
    check("rd_valid",  32'(bus16.rd_valid), 32'(e_rv));
    check("err",       32'(bus16.err),      32'(e_err));
    check("err_sat",   32'(bus4.err),       32'(e_err));
    check("data_out",  32'(bus16.data_out), 32'(e_data));
    check("data_sat",  32'(bus4.data_out),  32'(e_data));
    check("rd_count",  32'(bus16.rd_count), 32'(sat(rc, 65535)));
    check("wr_count",  32'(bus16.wr_count), 32'(sat(wc, 65535)));
    check("rd_cnt4",   32'(bus4.rd_count),  32'(sat(rc, 15)));
    check("wr_cnt4",   32'(bus4.wr_count),  32'(sat(wc, 15)));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  // Idle until busy falls; bounded so a stuck sweep cannot hang the run.
  task automatic sweep_count(output int n);
    n = 0;
    while (bus16.busy && n < 40) begin
      idle();
      n++;
    end
  endtask

  typedef struct {
    logic       r;
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] xdata;
    logic       xrv;
    logic       xerr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int n;
    rst = 1'b1;
    bus16.read = 1'b0; bus16.write = 1'b0; bus16.addr = '0; bus16.data_in = '0;
    bus4.read  = 1'b0; bus4.write  = 1'b0; bus4.addr  = '0; bus4.data_in  = '0;

    tbl[0] = '{1'b0, 1'b1, 5'd3, 8'h33, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 5'd5, 8'h5A, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 5'd5, 8'h00, 8'h5A, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 5'd3, 8'hAA, 8'h5A, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 5'd0, 8'h00, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 5'd3, 8'h00, 8'h33, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 5'd5, 8'h00, 8'h5A, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 5'd5, 8'hC3, 8'h5A, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 5'd5, 8'h00, 8'hC3, 1'b1, 1'b0};

    // Reset and sweep length, then all words read back as zero.
    do_reset(2);
    sweep_count(n);
    check("sweep_len", 32'(n), 32'd32);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
    check("rd_count_32", 32'(bus16.rd_count), 32'd32);
    check("rd_cnt4_sat", 32'(bus4.rd_count), 32'd15);

    // Constant pattern, then data equal to address.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 5'(i), 8'hE9);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 5'(i), 8'(i));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);

    // Directed vectors on a freshly cleared memory.
    do_reset(1);
    sweep_count(n);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
      check("tbl_data", 32'(bus16.data_out), 32'(tbl[i].xdata));
      check("tbl_rv",   32'(bus16.rd_valid), 32'(tbl[i].xrv));
      check("tbl_err",  32'(bus16.err),      32'(tbl[i].xerr));
    end
    check("tbl_rd_count", 32'(bus16.rd_count), 32'd4);
    check("tbl_wr_count", 32'(bus16.wr_count), 32'd3);

    // Read while busy at sweep edge 10: error pulse, sweep length unchanged.
    do_reset(1);
    for (int i = 0; i < 9; i++) idle();
    step(1'b0, 1'b1, 1'b0, 5'd7, 8'h00);
    check("busy_err", 32'(bus16.err), 32'd1);
    sweep_count(n);
    check("sweep_len_err", 32'(n + 10), 32'd32);

    // Reset at sweep edge 20 restarts the full sweep.
    do_reset(1);
    for (int i = 0; i < 19; i++) idle();
    do_reset(1);
    sweep_count(n);
    check("sweep_restart", 32'(n), 32'd32);

    // Reset from READY after filling with FF: contents and counters cleared.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 5'(i), 8'hFF);
    do_reset(1);
    check("rst_rd_count", 32'(bus16.rd_count), 32'd0);
    check("rst_wr_count", 32'(bus16.wr_count), 32'd0);
    sweep_count(n);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
      check("cleared_word", 32'(bus16.data_out), 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
